bch_decoder_input_dispatch: RTL and testbench
=============================================

Name: bch_decoder_input_dispatch

Overview:
Multi-channel successor to the single-decoder BCH input controller. It accepts one ECC control command at a time and forwards bypass traffic unchanged. For page and spare decodes it slices the source write stream into fixed-size chunks and sends each chunk to one of NumDecoders BCH decoders, chosen round-robin. Spare chunks are zero-padded internally. It sits between the ECC command/data front end and the decoder bank.

Parameters:
AddressWidth, 32, command address width
DataWidth, 32, data beat width (bits), power of 2, 8..256
InnerIFLengthWidth, 16, command length width
NumDecoders, 4, decoder channels, 1..8
PageChunkBeats, 64, source beats per page chunk
PageChunks, 32, chunks per page command, 1..128
SpareDataBeats, 16, source beats per spare chunk
SparePadBeats, 48, generated zero beats appended to a spare chunk

Ports:
iClock  in  1  clock
iReset  in  1  asynchronous active-low reset
iCmdSourceID/iCmdTargetID  in  5/5  command IDs
iCmdOpcode  in  6  opcode
iCmdType  in  2  00 bypass, 01 page, 10 spare, 11 errcnt
iCmdAddress  in  AddressWidth  address
iCmdLength  in  InnerIFLengthWidth  length
iCmdValid / oCmdReady  in/out  1  command handshake
oDstSourceID, oDstTargetID, oDstOpcode, oDstCmdType, oDstAddress, oDstLength  out  5,5,6,2,AW,ILW  latched command
oDstCmdValid / iDstCmdReady  out/in  1  downstream command handshake
iSrcWriteData  in  DataWidth  source data
iSrcWriteValid / iSrcWriteLast / oSrcWriteReady  in/in/out  1  source stream
oBypassWriteData  out  DataWidth  bypass data
oBypassWriteValid / oBypassWriteLast / iBypassWriteReady  out/out/in  1  bypass stream
oDecWriteData  out  DataWidth  shared decoder data bus
oDecWriteLast  out  1  last beat of chunk
oDecWriteValid  out  NumDecoders  one-hot valid
iDecWriteReady  in  NumDecoders  per-decoder ready
iDecAvailable  in  NumDecoders  decoder idle, can take a chunk
oChunkIndex  out  7  index of chunk in flight
oBusy  out  1  state != IDLE

Behaviour:
- Reset (iReset=0, async): state IDLE; all valids 0; oCmdReady 1; command regs, counters, round-robin pointer rRr all 0. Deassertion is used synchronously.
- oCmdReady = (state==IDLE). Command fields latch on iCmdValid&&oCmdReady.
- States: IDLE, BYP_CMD, BYP_TRF, ERR_CMD, PAGE_CMD, PAGE_SEL, PAGE_DATA, SPARE_SEL, SPARE_DATA, SPARE_PAD, SPARE_CMD.
- IDLE→BYP_CMD / PAGE_CMD / SPARE_SEL / ERR_CMD according to the type.
- oDstCmdValid=1 only in BYP_CMD, ERR_CMD, PAGE_CMD, SPARE_CMD. Each state exits on iDstCmdReady:
  - BYP_CMD→BYP_TRF, or →IDLE if length==0.
  - ERR_CMD→IDLE.
  - PAGE_CMD→PAGE_SEL.
  - SPARE_CMD→IDLE.
- BYP_TRF passes source to bypass combinationally: valid, last, data, and ready = iBypassWriteReady. Exit to IDLE on a valid&&last&&ready beat.
- PAGE_SEL/SPARE_SEL: choose the first decoder d with iDecAvailable[d], scanning from rRr upward modulo NumDecoders. Latch rSel. Move to the DATA state the next cycle. Stay while none is available.
- DATA states:
  - oDecWriteValid[rSel]=iSrcWriteValid, all other bits 0; oSrcWriteReady=iDecWriteReady[rSel].
  - A beat counter counts accepted beats.
  - oDecWriteLast=1 on beat PageChunkBeats-1 (page), or on the last pad beat (spare).
  - iSrcWriteLast is ignored for chunking.
- Page chunk end: rRr<=rSel+1 (mod N) and the chunk index increments. If the chunk index equals PageChunks-1, go to IDLE; otherwise go to PAGE_SEL.
- SPARE_DATA: after SpareDataBeats accepted beats, go to SPARE_PAD. If SparePadBeats==0, go straight to SPARE_CMD with last on the final data beat.
- SPARE_PAD:
  - oSrcWriteReady=0; data=0; valid[rSel]=1.
  - Counts beats accepted by iDecWriteReady[rSel].
  - After SparePadBeats, go to SPARE_CMD and advance rRr.
- Idle outputs: oDecWriteData=0 outside DATA/PAD; oBypassWriteData=0 outside BYP_TRF.
- Stalls: when ready is low, valid, data and last hold; the counters do not advance.
- Simultaneous events: an available bit rising in the same cycle as selection is honoured. iDecAvailable may fall mid-chunk and is ignored.
- oChunkIndex holds the current chunk number; it is 0 for spare.
- Counter widths are clog2 of the maximum count. Wrap is never reached.

Optional Feature:
Macro BCH_DISPATCH_LENCHECK_EN.
- Enabled: adds output oLenError (1 bit, sticky until the next accepted command).
  - Sets when an accepted source beat has iSrcWriteLast=1 but is not the final source beat of the command: page beat PageChunkBeats-1 of the last chunk, or spare data beat SpareDataBeats-1.
  - Also sets when the final source beat arrives with iSrcWriteLast=0.
  - Dispatch is unaffected.
- Disabled: port absent; no checking logic.

Test Plan:
- Page, N=4, all available, PageChunkBeats=4, PageChunks=3:
  - cmd type 01 → one dst command, then chunks go to decoders 0,1,2.
  - oDecWriteLast on every 4th beat; rRr ends at 3; IDLE after 12 beats.
- Round-robin skip: rRr=1, iDecAvailable=4'b1001 → decoder 3 selected. With 4'b0000 it waits in PAGE_SEL with oSrcWriteReady=0.
- Spare, SpareDataBeats=2, SparePadBeats=3:
  - 2 source beats forwarded, then 3 zero beats with oSrcWriteReady=0.
  - Last on the 5th beat, then SPARE_CMD, then IDLE.
- Bypass length 0 → IDLE immediately after iDstCmdReady, no data forwarded. Length>0 with backpressure → data held, exit on the last handshake.
- Async reset asserted mid PAGE_DATA → all valids 0 immediately; after release, IDLE with oCmdReady=1.
- With BCH_DISPATCH_LENCHECK_EN: iSrcWriteLast on page beat 2 of chunk 0 → oLenError=1 and it stays 1 until the next command.

Source files
------------

// File: rtl/bch_decoder_input_dispatch.sv
// bch_decoder_input_dispatch
//   Accepts one ECC command at a time. Bypass traffic is forwarded unchanged.
//   Page and spare decodes are sliced into fixed-size chunks, and each chunk
//   is sent to a BCH decoder chosen round-robin from the available ones.
//   Spare chunks are zero-padded here before they reach the decoder.
//   Optional: define BCH_DISPATCH_LENCHECK_EN to add a sticky oLenError output.
//   It flags a source stream whose iSrcWriteLast does not line up with the
//   final source beat of the command.
module bch_decoder_input_dispatch #(
    parameter int AddressWidth       = 32,
    parameter int DataWidth          = 32,
    parameter int InnerIFLengthWidth = 16,
    parameter int NumDecoders        = 4,
    parameter int PageChunkBeats     = 64,
    parameter int PageChunks         = 32,
    parameter int SpareDataBeats     = 16,
    parameter int SparePadBeats      = 48
) (
    input  logic                          iClock,
    input  logic                          iReset,
    input  logic [4:0]                    iCmdSourceID,
    input  logic [4:0]                    iCmdTargetID,
    input  logic [5:0]                    iCmdOpcode,
    input  logic [1:0]                    iCmdType,
    input  logic [AddressWidth-1:0]       iCmdAddress,
    input  logic [InnerIFLengthWidth-1:0] iCmdLength,
    input  logic                          iCmdValid,
    output logic                          oCmdReady,
    output logic [4:0]                    oDstSourceID,
    output logic [4:0]                    oDstTargetID,
    output logic [5:0]                    oDstOpcode,
    output logic [1:0]                    oDstCmdType,
    output logic [AddressWidth-1:0]       oDstAddress,
    output logic [InnerIFLengthWidth-1:0] oDstLength,
    output logic                          oDstCmdValid,
    input  logic                          iDstCmdReady,
    input  logic [DataWidth-1:0]          iSrcWriteData,
    input  logic                          iSrcWriteValid,
    input  logic                          iSrcWriteLast,
    output logic                          oSrcWriteReady,
    output logic [DataWidth-1:0]          oBypassWriteData,
    output logic                          oBypassWriteValid,
    output logic                          oBypassWriteLast,
    input  logic                          iBypassWriteReady,
    output logic [DataWidth-1:0]          oDecWriteData,
    output logic                          oDecWriteLast,
    output logic [NumDecoders-1:0]        oDecWriteValid,
    input  logic [NumDecoders-1:0]        iDecWriteReady,
    input  logic [NumDecoders-1:0]        iDecAvailable,
    output logic [6:0]                    oChunkIndex,
    output logic                          oBusy
`ifdef BCH_DISPATCH_LENCHECK_EN
    ,
    output logic                          oLenError
`endif
);

    localparam int MaxA     = (PageChunkBeats > SpareDataBeats) ? PageChunkBeats : SpareDataBeats;
    localparam int MaxBeats = (MaxA > SparePadBeats) ? MaxA : SparePadBeats;
    localparam int BeatW    = (MaxBeats > 1) ? $clog2(MaxBeats) : 1;
    localparam int SelW     = (NumDecoders > 1) ? $clog2(NumDecoders) : 1;
    localparam bit PadEn    = (SparePadBeats > 0);

    localparam logic [BeatW-1:0] PageLast  = BeatW'(PageChunkBeats - 1);
    localparam logic [BeatW-1:0] SpareLast = BeatW'(SpareDataBeats - 1);
    localparam logic [BeatW-1:0] PadLast   = BeatW'(PadEn ? SparePadBeats - 1 : 0);
    localparam logic [6:0]       LastChunk = 7'(PageChunks - 1);
    localparam logic [SelW-1:0]  LastDec   = SelW'(NumDecoders - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_BYP_CMD, S_BYP_TRF, S_ERR_CMD, S_PAGE_CMD, S_PAGE_SEL,
        S_PAGE_DATA, S_SPARE_SEL, S_SPARE_DATA, S_SPARE_PAD, S_SPARE_CMD
    } state_t;

    state_t                        state, state_nxt;
    logic [4:0]                    src_id, tgt_id;
    logic [5:0]                    opcode;
    logic [1:0]                    cmd_type;
    logic [AddressWidth-1:0]       address;
    logic [InnerIFLengthWidth-1:0] length;
    logic [SelW-1:0]               sel, rr, pick, cand;
    logic                          pick_found;
    logic [BeatW-1:0]              beat_cnt;
    logic [6:0]                    chunk_idx;

    logic cmd_acc, dec_rdy, data_acc, page_chunk_end, spare_data_end, pad_end;
    logic [SelW-1:0] rr_after_sel;

    assign cmd_acc        = iCmdValid && (state == S_IDLE);
    assign dec_rdy        = iDecWriteReady[sel];
    assign data_acc       = iSrcWriteValid && dec_rdy;
    assign page_chunk_end = (state == S_PAGE_DATA) && data_acc && (beat_cnt == PageLast);
    assign spare_data_end = (state == S_SPARE_DATA) && data_acc && (beat_cnt == SpareLast);
    assign pad_end        = (state == S_SPARE_PAD) && dec_rdy && (beat_cnt == PadLast);
    assign rr_after_sel   = (sel == LastDec) ? '0 : sel + SelW'(1);

    assign oCmdReady    = (state == S_IDLE);
    assign oBusy        = (state != S_IDLE);
    assign oDstSourceID = src_id;
    assign oDstTargetID = tgt_id;
    assign oDstOpcode   = opcode;
    assign oDstCmdType  = cmd_type;
    assign oDstAddress  = address;
    assign oDstLength   = length;
    assign oChunkIndex  = chunk_idx;

    // First available decoder at or after the round-robin pointer
    always_comb begin
        pick_found = 1'b0;
        pick       = '0;
        cand       = '0;
        for (int i = 0; i < NumDecoders; i++) begin
            cand = SelW'((int'(rr) + i) % NumDecoders);
            if (!pick_found && iDecAvailable[cand]) begin
                pick_found = 1'b1;
                pick       = cand;
            end
        end
    end

    // State register
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Next state and the combinational stream muxing
    always_comb begin
        state_nxt         = state;
        oDstCmdValid      = 1'b0;
        oSrcWriteReady    = 1'b0;
        oBypassWriteData  = '0;
        oBypassWriteValid = 1'b0;
        oBypassWriteLast  = 1'b0;
        oDecWriteData     = '0;
        oDecWriteLast     = 1'b0;
        oDecWriteValid    = '0;
        case (state)
            S_IDLE: begin
                if (iCmdValid) begin
                    case (iCmdType)
                        2'b00:   state_nxt = S_BYP_CMD;
                        2'b01:   state_nxt = S_PAGE_CMD;
                        2'b10:   state_nxt = S_SPARE_SEL;
                        default: state_nxt = S_ERR_CMD;
                    endcase
                end
            end
            S_BYP_CMD: begin
                oDstCmdValid = 1'b1;
                if (iDstCmdReady) state_nxt = (length == '0) ? S_IDLE : S_BYP_TRF;
            end
            S_BYP_TRF: begin
                oBypassWriteData  = iSrcWriteData;
                oBypassWriteValid = iSrcWriteValid;
                oBypassWriteLast  = iSrcWriteLast;
                oSrcWriteReady    = iBypassWriteReady;
                if (iSrcWriteValid && iSrcWriteLast && iBypassWriteReady) state_nxt = S_IDLE;
            end
            S_ERR_CMD: begin
                oDstCmdValid = 1'b1;
                if (iDstCmdReady) state_nxt = S_IDLE;
            end
            S_PAGE_CMD: begin
                oDstCmdValid = 1'b1;
                if (iDstCmdReady) state_nxt = S_PAGE_SEL;
            end
            S_PAGE_SEL: begin
                if (pick_found) state_nxt = S_PAGE_DATA;
            end
            S_PAGE_DATA: begin
                oDecWriteData       = iSrcWriteData;
                oDecWriteValid[sel] = iSrcWriteValid;
                oDecWriteLast       = (beat_cnt == PageLast);
                oSrcWriteReady      = dec_rdy;
                if (page_chunk_end) state_nxt = (chunk_idx == LastChunk) ? S_IDLE : S_PAGE_SEL;
            end
            S_SPARE_SEL: begin
                if (pick_found) state_nxt = S_SPARE_DATA;
            end
            S_SPARE_DATA: begin
                oDecWriteData       = iSrcWriteData;
                oDecWriteValid[sel] = iSrcWriteValid;
                oDecWriteLast       = !PadEn && (beat_cnt == SpareLast);
                oSrcWriteReady      = dec_rdy;
                if (spare_data_end) state_nxt = PadEn ? S_SPARE_PAD : S_SPARE_CMD;
            end
            S_SPARE_PAD: begin
                oDecWriteValid[sel] = 1'b1;
                oDecWriteLast       = (beat_cnt == PadLast);
                if (pad_end) state_nxt = S_SPARE_CMD;
            end
            S_SPARE_CMD: begin
                oDstCmdValid = 1'b1;
                if (iDstCmdReady) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Command latch on acceptance
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            src_id   <= '0;
            tgt_id   <= '0;
            opcode   <= '0;
            cmd_type <= '0;
            address  <= '0;
            length   <= '0;
        end else if (cmd_acc) begin
            src_id   <= iCmdSourceID;
            tgt_id   <= iCmdTargetID;
            opcode   <= iCmdOpcode;
            cmd_type <= iCmdType;
            address  <= iCmdAddress;
            length   <= iCmdLength;
        end
    end

    // Decoder selection and round-robin advance at chunk end
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            sel <= '0;
            rr  <= '0;
        end else begin
            if ((state == S_PAGE_SEL || state == S_SPARE_SEL) && pick_found) sel <= pick;
            if (page_chunk_end || pad_end || (spare_data_end && !PadEn)) rr <= rr_after_sel;
        end
    end

    // Beat counter within the chunk and chunk index within the command
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            beat_cnt  <= '0;
            chunk_idx <= '0;
        end else begin
            if (cmd_acc) chunk_idx <= '0;
            else if (page_chunk_end) chunk_idx <= chunk_idx + 7'd1;

            if (cmd_acc || page_chunk_end || spare_data_end || pad_end)
                beat_cnt <= '0;
            else if (((state == S_PAGE_DATA || state == S_SPARE_DATA) && data_acc) ||
                     (state == S_SPARE_PAD && dec_rdy))
                beat_cnt <= beat_cnt + BeatW'(1);
        end
    end

`ifdef BCH_DISPATCH_LENCHECK_EN
    logic len_err, page_final;
    assign page_final = (chunk_idx == LastChunk) && (beat_cnt == PageLast);
    assign oLenError  = len_err;

    // Sticky mismatch between iSrcWriteLast and the command's final source beat
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset)
            len_err <= 1'b0;
        else if (cmd_acc)
            len_err <= 1'b0;
        else if ((state == S_PAGE_DATA && data_acc && (iSrcWriteLast != page_final)) ||
                 (state == S_SPARE_DATA && data_acc && (iSrcWriteLast != (beat_cnt == SpareLast))))
            len_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_bch_decoder_input_dispatch.sv
// Self-checking bench for bch_decoder_input_dispatch.
// Randomised source/decoder handshakes are compared against a chunk-level
// model: round-robin pick over an availability mask, beat counts per chunk.
module tb_bch_decoder_input_dispatch;
    localparam int N   = 4;
    localparam int PCB = 4;
    localparam int PC  = 3;
    localparam int SDB = 2;
    localparam int SPB = 3;

    logic        iClock = 1'b0;
    logic        iReset = 1'b0;
    logic [4:0]  iCmdSourceID = '0, iCmdTargetID = '0;
    logic [5:0]  iCmdOpcode = '0;
    logic [1:0]  iCmdType = '0;
    logic [31:0] iCmdAddress = '0;
    logic [15:0] iCmdLength = '0;
    logic        iCmdValid = 1'b0, oCmdReady;
    logic [4:0]  oDstSourceID, oDstTargetID;
    logic [5:0]  oDstOpcode;
    logic [1:0]  oDstCmdType;
    logic [31:0] oDstAddress;
    logic [15:0] oDstLength;
    logic        oDstCmdValid, iDstCmdReady = 1'b0;
    logic [31:0] iSrcWriteData = '0;
    logic        iSrcWriteValid = 1'b0, iSrcWriteLast = 1'b0, oSrcWriteReady;
    logic [31:0] oBypassWriteData;
    logic        oBypassWriteValid, oBypassWriteLast, iBypassWriteReady = 1'b0;
    logic [31:0] oDecWriteData;
    logic        oDecWriteLast;
    logic [N-1:0] oDecWriteValid, iDecWriteReady = '0, iDecAvailable = '0;
    logic [6:0]  oChunkIndex;
    logic        oBusy;
`ifdef BCH_DISPATCH_LENCHECK_EN
    logic        oLenError;
`endif

    bch_decoder_input_dispatch #(
        .AddressWidth(32), .DataWidth(32), .InnerIFLengthWidth(16), .NumDecoders(N),
        .PageChunkBeats(PCB), .PageChunks(PC), .SpareDataBeats(SDB), .SparePadBeats(SPB)
    ) dut (
        .iClock(iClock), .iReset(iReset),
        .iCmdSourceID(iCmdSourceID), .iCmdTargetID(iCmdTargetID), .iCmdOpcode(iCmdOpcode),
        .iCmdType(iCmdType), .iCmdAddress(iCmdAddress), .iCmdLength(iCmdLength),
        .iCmdValid(iCmdValid), .oCmdReady(oCmdReady),
        .oDstSourceID(oDstSourceID), .oDstTargetID(oDstTargetID), .oDstOpcode(oDstOpcode),
        .oDstCmdType(oDstCmdType), .oDstAddress(oDstAddress), .oDstLength(oDstLength),
        .oDstCmdValid(oDstCmdValid), .iDstCmdReady(iDstCmdReady),
        .iSrcWriteData(iSrcWriteData), .iSrcWriteValid(iSrcWriteValid),
        .iSrcWriteLast(iSrcWriteLast), .oSrcWriteReady(oSrcWriteReady),
        .oBypassWriteData(oBypassWriteData), .oBypassWriteValid(oBypassWriteValid),
        .oBypassWriteLast(oBypassWriteLast), .iBypassWriteReady(iBypassWriteReady),
        .oDecWriteData(oDecWriteData), .oDecWriteLast(oDecWriteLast),
        .oDecWriteValid(oDecWriteValid), .iDecWriteReady(iDecWriteReady),
        .iDecAvailable(iDecAvailable), .oChunkIndex(oChunkIndex), .oBusy(oBusy)
`ifdef BCH_DISPATCH_LENCHECK_EN
        , .oLenError(oLenError)
`endif
    );

    always #5 iClock = ~iClock;

    int tests = 0;
    int fails = 0;
    int m_rr  = 0;
    logic [33:0] e_hdr;
    logic [31:0] e_addr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every task starts and ends one time unit after a rising edge
    task automatic tick();
        @(posedge iClock);
        #1;
    endtask

    function automatic int pick(input logic [3:0] av, input int rr);
        for (int i = 0; i < N; i++)
            if (av[(rr + i) % N]) return (rr + i) % N;
        return -1;
    endfunction

    task automatic dst_handshake();
        int d;
        d = $urandom_range(0, 2);
        for (int k = 0; k <= d; k++) begin
            iDstCmdReady = (k == d);
            #1;
            chk("dst_valid", oDstCmdValid, 1);
            chk("dst_hdr", {oDstSourceID, oDstTargetID, oDstOpcode, oDstCmdType, oDstLength}, e_hdr);
            chk("dst_addr", oDstAddress, e_addr);
            chk("cmd_ready_busy", oCmdReady, 0);
            tick();
        end
        iDstCmdReady = 1'b0;
    endtask

    task automatic send_cmd(input logic [1:0] typ, input logic [15:0] len);
        iCmdValid    = 1'b1;
        iCmdType     = typ;
        iCmdLength   = len;
        iCmdSourceID = 5'($urandom);
        iCmdTargetID = 5'($urandom);
        iCmdOpcode   = 6'($urandom);
        iCmdAddress  = $urandom;
        e_hdr  = {iCmdSourceID, iCmdTargetID, iCmdOpcode, typ, len};
        e_addr = iCmdAddress;
        #1;
        chk("cmd_ready_idle", oCmdReady, 1);
        tick();
        iCmdValid   = 1'b0;
        iCmdAddress = $urandom;
        iCmdType    = 2'($urandom);
        iCmdLength  = 16'($urandom);
`ifdef BCH_DISPATCH_LENCHECK_EN
        #0;
        chk("len_err_clear", oLenError, 0);
`endif
        if (typ != 2'b10) dst_handshake();
    endtask

    task automatic check_idle();
        #1;
        chk("idle_busy", oBusy, 0);
        chk("idle_cmd_ready", oCmdReady, 1);
        chk("idle_dec_valid", oDecWriteValid, 0);
        tick();
    endtask

    // Stream one chunk to decoder dec; bad marks a data beat forced to carry last
    task automatic stream(input int dec, input int nbeats, input int npad, input bit page,
                          input int chunk, input int bad);
        int acc = 0, p = 0, budget = 0;
        logic v, fin;
        logic [3:0] rdy, oh;
        oh = 4'b0001 << dec;
        while (acc < nbeats && budget < 200) begin
            v   = ($urandom_range(0, 3) != 0);
            rdy = 4'($urandom);
            fin = page ? (chunk == PC - 1 && acc == PCB - 1) : (acc == SDB - 1);
            iSrcWriteValid = v;
            iSrcWriteData  = $urandom;
            iSrcWriteLast  = (acc == bad) ? 1'b1 : fin;
            iDecWriteReady = rdy;
            iDecAvailable  = 4'($urandom);
            #1;
            chk("dec_valid", oDecWriteValid, v ? oh : 4'b0);
            chk("src_ready", oSrcWriteReady, rdy[dec]);
            chk("dec_data", oDecWriteData, iSrcWriteData);
            chk("chunk_idx", oChunkIndex, page ? chunk : 0);
            if (v) chk("dec_last", oDecWriteLast, page ? (acc == PCB - 1) : (npad == 0 && acc == SDB - 1));
            if (v && rdy[dec]) acc++;
            budget++;
            tick();
        end
        chk("beats_done", acc, nbeats);
        iSrcWriteLast = 1'b0;
        while (p < npad && budget < 400) begin
            rdy = 4'($urandom);
            iSrcWriteValid = $urandom_range(0, 1) != 0;
            iSrcWriteData  = $urandom;
            iDecWriteReady = rdy;
            #1;
            chk("pad_valid", oDecWriteValid, oh);
            chk("pad_data", oDecWriteData, 0);
            chk("pad_src_ready", oSrcWriteReady, 0);
            chk("pad_last", oDecWriteLast, p == npad - 1);
            if (rdy[dec]) p++;
            budget++;
            tick();
        end
        chk("pad_done", p, npad);
        iSrcWriteValid = 1'b0;
    endtask

    task automatic select(input logic [3:0] av, input int stall, output int dec);
        for (int s = 0; s < stall; s++) begin
            iDecAvailable  = '0;
            iSrcWriteValid = 1'b1;
            #1;
            chk("sel_wait_ready", oSrcWriteReady, 0);
            chk("sel_wait_valid", oDecWriteValid, 0);
            chk("sel_wait_busy", oBusy, 1);
            tick();
        end
        iDecAvailable = av;
        dec = pick(av, m_rr);
        #1;
        chk("sel_valid", oDecWriteValid, 0);
        chk("sel_dst_valid", oDstCmdValid, 0);
        tick();
    endtask

    task automatic run_page(input logic [11:0] avs, input int stall0, input int bad0);
        int dec;
        send_cmd(2'b01, 16'($urandom));
        for (int c = 0; c < PC; c++) begin
            select(avs[c*4 +: 4], (c == 0) ? stall0 : 0, dec);
            stream(dec, PCB, 0, 1'b1, c, (c == 0) ? bad0 : -1);
            m_rr = (dec + 1) % N;
        end
`ifdef BCH_DISPATCH_LENCHECK_EN
        chk("len_err", oLenError, bad0 >= 0);
`endif
        check_idle();
    endtask

    task automatic run_spare(input logic [3:0] av);
        int dec;
        send_cmd(2'b10, 16'($urandom));
        select(av, 0, dec);
        stream(dec, SDB, SPB, 1'b0, 0, -1);
        m_rr = (dec + 1) % N;
        dst_handshake();
`ifdef BCH_DISPATCH_LENCHECK_EN
        chk("len_err_spare", oLenError, 0);
`endif
        check_idle();
    endtask

    task automatic run_bypass(input logic [15:0] len, input int nbeats);
        int sent = 0, budget = 0;
        logic v, br;
        send_cmd(2'b00, len);
        while (len != 0 && sent < nbeats && budget < 200) begin
            v  = $urandom_range(0, 1) != 0;
            br = $urandom_range(0, 1) != 0;
            iSrcWriteValid    = v;
            iSrcWriteData     = $urandom;
            iSrcWriteLast     = (sent == nbeats - 1);
            iBypassWriteReady = br;
            #1;
            chk("byp_valid", oBypassWriteValid, v);
            chk("byp_data", oBypassWriteData, iSrcWriteData);
            chk("byp_last", oBypassWriteLast, iSrcWriteLast);
            chk("byp_src_ready", oSrcWriteReady, br);
            chk("byp_dec_valid", oDecWriteValid, 0);
            if (v && br) sent++;
            budget++;
            tick();
        end
        if (len != 0) chk("byp_done", sent, nbeats);
        iSrcWriteValid = 1'b0;
        iSrcWriteLast  = 1'b0;
        check_idle();
    endtask

    initial begin
        int dec;
        logic [3:0] a0, a1, a2;
        // Reset state
        tick();
        chk("rst_cmd_ready", oCmdReady, 1);
        chk("rst_busy", oBusy, 0);
        chk("rst_dec_valid", oDecWriteValid, 0);
        chk("rst_dst_valid", oDstCmdValid, 0);
        chk("rst_byp_valid", oBypassWriteValid, 0);
        chk("rst_chunk", oChunkIndex, 0);
        iReset = 1'b1;
        tick();

        // Idle: data buses stay zero
        iSrcWriteValid = 1'b1;
        iSrcWriteData  = 32'hA5A5_5A5A;
        #1;
        chk("idle_byp_data", oBypassWriteData, 0);
        chk("idle_dec_data", oDecWriteData, 0);
        chk("idle_byp_valid", oBypassWriteValid, 0);
        chk("idle_src_ready", oSrcWriteReady, 0);
        tick();
        iSrcWriteValid = 1'b0;

        // Page, all available: decoders 0,1,2 and pointer ends at 3
        run_page(12'hFFF, 0, -1);
        // Spare from pointer 3 -> decoder 3, pointer wraps to 0
        run_spare(4'hF);
        // Page: wait with none available, then 0001 -> 0; then 1001 from 1 -> 3
        run_page({4'b0110, 4'b1001, 4'b0001}, 3, -1);

        // Bypass and error-count commands
        run_bypass(16'd0, 0);
        run_bypass(16'd5, 5);
        send_cmd(2'b11, 16'($urandom));
        check_idle();

        // Randomised page/spare mix with arbitrary nonzero availability
        for (int r = 0; r < 6; r++) begin
            a0 = 4'($urandom_range(1, 15));
            a1 = 4'($urandom_range(1, 15));
            a2 = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 1) != 0) run_page({a2, a1, a0}, $urandom_range(0, 2), -1);
            else run_spare(a0);
        end

        // Asynchronous reset in the middle of a page chunk
        send_cmd(2'b01, 16'd7);
        select(4'hF, 0, dec);
        iSrcWriteValid = 1'b1;
        iDecWriteReady = '0;
        #1;
        chk("pre_rst_valid", oDecWriteValid, 4'b0001 << dec);
        iReset = 1'b0;
        #1;
        chk("async_rst_valid", oDecWriteValid, 0);
        chk("async_rst_busy", oBusy, 0);
        tick();
        iSrcWriteValid = 1'b0;
        iReset = 1'b1;
        m_rr = 0;
        tick();
        chk("post_rst_cmd_ready", oCmdReady, 1);
        chk("post_rst_busy", oBusy, 0);
        // Pointer cleared by reset: all available selects decoder 0 first
        run_page(12'hFFF, 0, -1);

`ifdef BCH_DISPATCH_LENCHECK_EN
        // Early last on beat 2 of chunk 0 is flagged and stays set until next command
        run_page(12'hFFF, 0, 2);
        run_spare(4'hF);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
